bcd_digit_entry: RTL and testbench

- Keypad-style entry block that builds a 4-digit packed BCD word from switch and pushbutton input.
- It is the writer side of the 4-digit BCD-to-7-segment display path: BCD_OUT[15:12] feeds HEX7 and BCD_OUT[3:0] feeds HEX4.
- The display shows any nibble greater than 9 as blank, so 4'hF marks an empty position.
- Sits between the board pins (SW, KEY) and the display decoder.

---
 rtl/bcd_digit_entry.sv | 163 ++++++++++++++++
 tb/tb_bcd_digit_entry.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: keypad-style entry of a 4-digit packed BCD word.
// Buttons are synchronized, debounced and edge-detected. Each accepted press
// then updates the digit buffer that drives the 7-segment display path.
// The newest digit sits in BCD_OUT[3:0].
// Optional build macro BCD_ENTRY_ZERO_FILL_EN makes empty positions read 4'h0
// (leading zeros on the display). The default fill is 4'hF, which shows as blank.
module bcd_digit_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 19
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [3:0]  DIGIT_IN,
   input  logic        ENTER_N,
   input  logic        BKSP_N,
   input  logic        CLEAR_N,
   output logic [15:0] BCD_OUT,
   output logic [2:0]  DIGIT_CNT,
   output logic        UPDATE,
   output logic        ERR
);

   localparam int unsigned NUM_BTN   = 3;
   localparam int unsigned BTN_ENTER = 0;
   localparam int unsigned BTN_BKSP  = 1;
   localparam int unsigned BTN_CLEAR = 2;
   localparam int unsigned DIG_W     = 4;
   localparam int unsigned CNT_OUT_W = 3;
   // Arm counter is one bit wider so it can reach DEBOUNCE_CYCLES + 2.
   localparam int unsigned ARM_W     = CNT_W + 1;
   localparam logic [CNT_OUT_W-1:0] MAX_DIGITS = CNT_OUT_W'(4);

`ifdef BCD_ENTRY_ZERO_FILL_EN
   localparam logic [DIG_W-1:0] FILL_NIB = 4'h0;
`else
   localparam logic [DIG_W-1:0] FILL_NIB = 4'hF;
`endif

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] btn_s1;
   logic [NUM_BTN-1:0] btn_s2;
   logic [DIG_W-1:0]   dig_s1;
   logic [DIG_W-1:0]   dig_s2;
   logic [NUM_BTN-1:0] press;

   logic [15:0]          bcd_nxt;
   logic [CNT_OUT_W-1:0] cnt_nxt;
   logic                 err_nxt;
   logic                 upd_nxt;

   assign btn_raw = {CLEAR_N, BKSP_N, ENTER_N};

   // Two-flop synchronizers for every button and every digit bit.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         btn_s1 <= '1;
         btn_s2 <= '1;
         dig_s1 <= '1;
         dig_s2 <= '1;
      end else begin
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
         dig_s1 <= DIGIT_IN;
         dig_s2 <= dig_s1;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      logic [CNT_W-1:0] deb_cnt;
      logic             deb_lvl;
      logic [ARM_W-1:0] arm_cnt;
      logic             armed;
      logic             evt;

      // Debounce the synchronized level and emit a one-cycle event on an
      // accepted 1->0 change. The button is not armed after reset until it
      // has been seen released for DEBOUNCE_CYCLES+2 samples. That is longer
      // than the two reset-valued synchronizer samples, so a button held
      // through reset never fires.
      always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
         if (!RESET_N) begin
            deb_cnt <= '0;
            deb_lvl <= 1'b1;
            arm_cnt <= '0;
            armed   <= 1'b0;
            evt     <= 1'b0;
         end else begin
            evt <= 1'b0;
            if (btn_s2[g] != deb_lvl) begin
               if (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  deb_lvl <= btn_s2[g];
                  deb_cnt <= '0;
                  evt     <= armed & ~btn_s2[g];
               end else begin
                  deb_cnt <= deb_cnt + CNT_W'(1);
               end
            end else begin
               deb_cnt <= '0;
            end
            if (!armed) begin
               if (btn_s2[g] && deb_lvl) begin
                  if (arm_cnt == ARM_W'(DEBOUNCE_CYCLES + 1)) begin
                     armed <= 1'b1;
                  end else begin
                     arm_cnt <= arm_cnt + ARM_W'(1);
                  end
               end else begin
                  arm_cnt <= '0;
               end
            end
         end
      end

      assign press[g] = evt;
   end

   // Next buffer state. CLEAR has priority over BKSP, and BKSP over ENTER.
   always_comb begin
      bcd_nxt = BCD_OUT;
      cnt_nxt = DIGIT_CNT;
      err_nxt = ERR;
      upd_nxt = 1'b0;
      if (press[BTN_CLEAR]) begin
         bcd_nxt = {4{FILL_NIB}};
         cnt_nxt = '0;
         err_nxt = 1'b0;
         upd_nxt = 1'b1;
      end else if (press[BTN_BKSP]) begin
         if (DIGIT_CNT != '0) begin
            bcd_nxt = {FILL_NIB, BCD_OUT[15:4]};
            cnt_nxt = DIGIT_CNT - CNT_OUT_W'(1);
            upd_nxt = 1'b1;
         end
      end else if (press[BTN_ENTER]) begin
         if (dig_s2 <= DIG_W'(9)) begin
            bcd_nxt = {BCD_OUT[11:0], dig_s2};
            err_nxt = 1'b0;
            upd_nxt = 1'b1;
            if (DIGIT_CNT != MAX_DIGITS) begin
               cnt_nxt = DIGIT_CNT + CNT_OUT_W'(1);
            end
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   // Registered buffer and status outputs.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         BCD_OUT   <= {4{FILL_NIB}};
         DIGIT_CNT <= '0;
         UPDATE    <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         BCD_OUT   <= bcd_nxt;
         DIGIT_CNT <= cnt_nxt;
         UPDATE    <= upd_nxt;
         ERR       <= err_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Directed bench for bcd_digit_entry with DEBOUNCE_CYCLES=4 (default blank fill).
module tb_bcd_digit_entry;

   logic        clk;
   logic        rst_n;
   logic [3:0]  digit_in;
   logic        enter_n;
   logic        bksp_n;
   logic        clear_n;
   logic [15:0] bcd_out;
   logic [2:0]  digit_cnt;
   logic        update;
   logic        err;

   int tests_run;
   int tests_failed;

   bcd_digit_entry #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(3)
   ) dut (
      .CLOCK_50 (clk),
      .RESET_N  (rst_n),
      .DIGIT_IN (digit_in),
      .ENTER_N  (enter_n),
      .BKSP_N   (bksp_n),
      .CLEAR_N  (clear_n),
      .BCD_OUT  (bcd_out),
      .DIGIT_CNT(digit_cnt),
      .UPDATE   (update),
      .ERR      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Press the buttons in mask (bit0 ENTER, bit1 BKSP, bit2 CLEAR) for 12 cycles,
   // then release for 12 cycles. Returns the UPDATE pulse count and the first
   // pulse's cycle offset from the press edge (-1 if none).
   task automatic press(input logic [2:0] mask, input logic [3:0] d,
                        output int n_upd, output int lat);
      n_upd = 0;
      lat   = -1;
      @(posedge clk); #1;
      digit_in = d;
      if (mask[0]) enter_n = 1'b0;
      if (mask[1]) bksp_n  = 1'b0;
      if (mask[2]) clear_n = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (update === 1'b1) begin
            n_upd++;
            if (lat < 0) lat = i;
         end
      end
      enter_n = 1'b1;
      bksp_n  = 1'b1;
      clear_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (update === 1'b1) n_upd++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      digit_in = 4'h0;
      enter_n = 1'b1;
      bksp_n = 1'b1;
      clear_n = 1'b1;
      idle(3);
      tests_run++; if (bcd_out !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_bcd got %h want ffff", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt got %0d want 0", digit_cnt); end
      tests_run++; if (update !== 1'b0) begin tests_failed++; $display("FAIL reset_update got %b want 0", update); end
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", err); end
      rst_n = 1'b1;
      idle(12);
   endtask

   task automatic test_enter();
      logic [3:0]  digs [3];
      logic [15:0] exp_bcd [3];
      int n, lat;
      digs[0] = 4'd3; digs[1] = 4'd1; digs[2] = 4'd4;
      exp_bcd[0] = 16'hFFF3; exp_bcd[1] = 16'hFF31; exp_bcd[2] = 16'hF314;
      for (int k = 0; k < 3; k++) begin
         press(3'b001, digs[k], n, lat);
         tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL enter%0d_pulses got %0d want 1", k, n); end
         tests_run++; if (lat !== 7) begin tests_failed++; $display("FAIL enter%0d_latency got %0d want 7", k, lat); end
         tests_run++; if (bcd_out !== exp_bcd[k]) begin tests_failed++; $display("FAIL enter%0d_bcd got %h want %h", k, bcd_out, exp_bcd[k]); end
         tests_run++; if (digit_cnt !== 3'(k + 1)) begin tests_failed++; $display("FAIL enter%0d_cnt got %0d want %0d", k, digit_cnt, k + 1); end
      end
   endtask

   task automatic test_backspace();
      logic [15:0] exp_bcd [4];
      int n, lat;
      exp_bcd[0] = 16'hFF31; exp_bcd[1] = 16'hFFF3; exp_bcd[2] = 16'hFFFF; exp_bcd[3] = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         press(3'b010, 4'h0, n, lat);
         tests_run++; if (n !== ((k < 3) ? 1 : 0)) begin tests_failed++; $display("FAIL bksp%0d_pulses got %0d want %0d", k, n, (k < 3) ? 1 : 0); end
         tests_run++; if (bcd_out !== exp_bcd[k]) begin tests_failed++; $display("FAIL bksp%0d_bcd got %h want %h", k, bcd_out, exp_bcd[k]); end
         tests_run++; if (digit_cnt !== ((k < 3) ? 3'(2 - k) : 3'd0)) begin tests_failed++; $display("FAIL bksp%0d_cnt got %0d", k, digit_cnt); end
      end
   endtask

   task automatic test_wrap();
      int n, lat;
      for (int k = 1; k <= 4; k++) press(3'b001, 4'(k), n, lat);
      tests_run++; if (bcd_out !== 16'h1234) begin tests_failed++; $display("FAIL fill4_bcd got %h want 1234", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd4) begin tests_failed++; $display("FAIL fill4_cnt got %0d want 4", digit_cnt); end
      press(3'b001, 4'd5, n, lat);
      tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL wrap_pulses got %0d want 1", n); end
      tests_run++; if (bcd_out !== 16'h2345) begin tests_failed++; $display("FAIL wrap_bcd got %h want 2345", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd4) begin tests_failed++; $display("FAIL wrap_cnt got %0d want 4", digit_cnt); end
   endtask

   task automatic test_error();
      int n, lat;
      press(3'b001, 4'hA, n, lat);
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_set got %b want 1", err); end
      tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL err_pulses got %0d want 0", n); end
      tests_run++; if (bcd_out !== 16'h2345) begin tests_failed++; $display("FAIL err_bcd got %h want 2345", bcd_out); end
      press(3'b010, 4'h0, n, lat);
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL err_bksp_keep got %b want 1", err); end
      tests_run++; if (bcd_out !== 16'hF234) begin tests_failed++; $display("FAIL err_bksp_bcd got %h want f234", bcd_out); end
      press(3'b001, 4'd7, n, lat);
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL err_clear_on_enter got %b want 0", err); end
      tests_run++; if (bcd_out !== 16'h2347) begin tests_failed++; $display("FAIL err_enter7_bcd got %h want 2347", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd4) begin tests_failed++; $display("FAIL err_enter7_cnt got %0d want 4", digit_cnt); end
   endtask

   task automatic test_glitch();
      int n;
      n = 0;
      @(posedge clk); #1;
      digit_in = 4'd9;
      enter_n = 1'b0;
      idle(3);
      enter_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (update === 1'b1) n++;
      end
      tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL glitch_pulses got %0d want 0", n); end
      tests_run++; if (bcd_out !== 16'h2347) begin tests_failed++; $display("FAIL glitch_bcd got %h want 2347", bcd_out); end
   endtask

   task automatic test_clear_priority();
      int n, lat;
      press(3'b001, 4'hB, n, lat);
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL prio_err_pre got %b want 1", err); end
      press(3'b101, 4'd9, n, lat);
      tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL prio_pulses got %0d want 1", n); end
      tests_run++; if (bcd_out !== 16'hFFFF) begin tests_failed++; $display("FAIL prio_bcd got %h want ffff", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL prio_cnt got %0d want 0", digit_cnt); end
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL prio_err got %b want 0", err); end
      press(3'b100, 4'd0, n, lat);
      tests_run++; if (n !== 1) begin tests_failed++; $display("FAIL clear_empty_pulses got %0d want 1", n); end
      press(3'b110, 4'd0, n, lat);
      press(3'b011, 4'd6, n, lat);
      tests_run++; if (bcd_out !== 16'hFFFF) begin tests_failed++; $display("FAIL bksp_over_enter_bcd got %h want ffff", bcd_out); end
      tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL bksp_over_enter_pulses got %0d want 0", n); end
   endtask

   task automatic test_reset_mid();
      int n, lat;
      press(3'b001, 4'd8, n, lat);
      tests_run++; if (bcd_out !== 16'hFFF8) begin tests_failed++; $display("FAIL mid_pre_bcd got %h want fff8", bcd_out); end
      @(posedge clk); #1;
      digit_in = 4'd6;
      enter_n = 1'b0;
      idle(4);
      #2;
      rst_n = 1'b0;
      #1;
      tests_run++; if (bcd_out !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_async_bcd got %h want ffff", bcd_out); end
      tests_run++; if (digit_cnt !== 3'd0) begin tests_failed++; $display("FAIL mid_async_cnt got %0d want 0", digit_cnt); end
      idle(2);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk); #1;
         if (update === 1'b1) n++;
      end
      tests_run++; if (n !== 0) begin tests_failed++; $display("FAIL mid_held_pulses got %0d want 0", n); end
      tests_run++; if (bcd_out !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_held_bcd got %h want ffff", bcd_out); end
      enter_n = 1'b1;
      idle(20);
      press(3'b001, 4'd6, n, lat);
      tests_run++; if (lat !== 7) begin tests_failed++; $display("FAIL mid_fresh_latency got %0d want 7", lat); end
      tests_run++; if (bcd_out !== 16'hFFF6) begin tests_failed++; $display("FAIL mid_fresh_bcd got %h want fff6", bcd_out); end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      test_reset();
      test_enter();
      test_backspace();
      test_enter();
      test_wrap();
      test_error();
      test_glitch();
      test_clear_priority();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
